// File: rtl/pcie_cpld_tx_generator.sv
// Completer-side CplD builder: splits a read request into MAX_PAYLOAD_DW completions and streams
// 3DW-header TLPs with QW-aligned payload onto a 256-bit Avalon-ST TX interface.
module pcie_cpld_tx_generator #(
  parameter int unsigned MAX_PAYLOAD_DW = 16
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic [15:0]  i_cfg_completer_id,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [9:0]   i_req_len_dw,
  input  logic [7:0]   i_req_tag,
  input  logic [15:0]  i_req_requester_id,
  input  logic [6:0]   i_req_lower_addr,
  output logic         o_req_err,
  input  logic [255:0] i_din_data,
  input  logic         i_din_valid,
  output logic         o_din_ready,
  output logic [255:0] o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_tx_sop,
  output logic         o_tx_eop,
  output logic [1:0]   o_tx_empty
);

  localparam logic [10:0] MpsDw = 11'(MAX_PAYLOAD_DW);

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  state_e         r_state, w_state_nxt;
  logic           r_armed, r_err;
  logic [15:0]    r_cpl_id, r_req_id;
  logic [7:0]     r_tag;
  logic [6:0]     r_addr;
  logic [10:0]    r_rem;
  logic [7:0]     r_in_left, r_out_left;
  logic [127:0]   r_residue;
  logic [255:0]   r_tx_data;
  logic           r_tx_valid, r_tx_sop, r_tx_eop;
  logic [1:0]     r_tx_empty;

  logic           w_accept, w_addr_bad, w_load, w_push, w_sop, w_eop, w_chunk_done, w_din_last;
  logic [10:0]    w_n;
  logic [7:0]     w_in_beats, w_out_beats;
  logic [3:0]     w_last_cnt, w_din_cnt, w_used;
  logic [2:0]     w_used_mod;
  logic [1:0]     w_empty;
  logic [255:0]   w_din_m, w_beat;
  logic [127:0]   w_hdr;

  // r_armed keeps req_ready low until the first clock after reset release
  assign o_req_ready = r_armed && (r_state == StIdle);
  assign o_req_err   = r_err;
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_sop    = r_tx_sop;
  assign o_tx_eop    = r_tx_eop;
  assign o_tx_empty  = r_tx_empty;

  assign w_accept   = i_req_valid && o_req_ready;
  assign w_addr_bad = (i_req_lower_addr[2:0] != 3'd0);
  assign w_load     = !r_tx_valid || i_tx_ready;

  assign w_n         = (r_rem > MpsDw) ? MpsDw : r_rem;
  assign w_in_beats  = 8'((w_n + 11'd7) >> 3);
  assign w_out_beats = 8'((w_n + 11'd11) >> 3);
  assign w_last_cnt  = {1'b0, 3'(w_n[2:0] - 3'd1)} + 4'd1;
  assign w_used_mod  = 3'(w_n[2:0] + 3'd4);
  assign w_used      = (w_used_mod == 3'd0) ? 4'd8 : {1'b0, w_used_mod};
  assign w_empty     = 2'((4'd8 - w_used) >> 1);

  // Only the final input beat of a chunk can be partial; its surplus DWs are zeroed
  assign w_din_last = (r_state == StHdr) ? (w_in_beats == 8'd1) : (r_in_left == 8'd1);
  assign w_din_cnt  = w_din_last ? w_last_cnt : 4'd8;

  always_comb begin
    w_din_m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < w_din_cnt) w_din_m[32*i +: 32] = i_din_data[32*i +: 32];
    end
  end

  assign w_hdr = {32'h0,
                  r_req_id, r_tag, 1'b0, r_addr,
                  r_cpl_id, 4'h0, r_rem[9:0], 2'b00,
                  3'b010, 5'b01010, 14'h0, w_n[9:0]};

  always_comb begin
    w_state_nxt  = r_state;
    o_din_ready  = 1'b0;
    w_push       = 1'b0;
    w_beat       = '0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_chunk_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_addr_bad) w_state_nxt = StHdr;
      end
      StHdr: begin
        o_din_ready = w_load;
        if (w_load && i_din_valid) begin
          w_push = 1'b1;
          w_sop  = 1'b1;
          w_beat = {w_din_m[127:0], w_hdr};
          if (w_out_beats == 8'd1) begin
            w_eop        = 1'b1;
            w_chunk_done = 1'b1;
          end else begin
            w_state_nxt = StBody;
          end
        end
      end
      StBody: begin
        o_din_ready = w_load && (r_in_left != 8'd0);
        if (w_load && ((r_in_left == 8'd0) || i_din_valid)) begin
          w_push = 1'b1;
          w_beat = {((r_in_left != 8'd0) ? w_din_m[127:0] : 128'h0), r_residue};
          if (r_out_left == 8'd1) begin
            w_eop        = 1'b1;
            w_chunk_done = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_chunk_done) w_state_nxt = (r_rem == w_n) ? StIdle : StHdr;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_armed    <= 1'b0;
      r_err      <= 1'b0;
      r_cpl_id   <= '0;
      r_req_id   <= '0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_in_left  <= '0;
      r_out_left <= '0;
      r_residue  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_empty <= '0;
    end else begin
      r_armed <= 1'b1;
      r_state <= w_state_nxt;
      r_err   <= w_accept && w_addr_bad;
      if (w_accept && !w_addr_bad) begin
        r_cpl_id <= i_cfg_completer_id;
        r_req_id <= i_req_requester_id;
        r_tag    <= i_req_tag;
        r_addr   <= i_req_lower_addr;
        r_rem    <= (i_req_len_dw == 10'd0) ? 11'd1024 : {1'b0, i_req_len_dw};
      end
      if (w_push) begin
        if (r_state == StHdr) begin
          r_in_left  <= w_in_beats - 8'd1;
          r_out_left <= w_out_beats - 8'd1;
          r_residue  <= w_din_m[255:128];
        end else begin
          r_out_left <= r_out_left - 8'd1;
          if (r_in_left != 8'd0) begin
            r_in_left <= r_in_left - 8'd1;
            r_residue <= w_din_m[255:128];
          end else begin
            r_residue <= '0;
          end
        end
      end
      if (w_chunk_done) begin
        r_rem  <= r_rem - w_n;
        r_addr <= r_addr + {w_n[4:0], 2'b00};
      end
      if (w_load) begin
        r_tx_valid <= w_push;
        r_tx_data  <= w_beat;
        r_tx_sop   <= w_sop;
        r_tx_eop   <= w_eop;
        r_tx_empty <= w_eop ? w_empty : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_cpld_tx_generator.sv
// Bench for pcie_cpld_tx_generator: directed vector table, stall/reset corner cases and random
// requests, all scored against a DW-list model of the completion stream.
module tb_pcie_cpld_tx_generator;
  localparam int MPS = 16;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic [15:0]  i_cfg_completer_id;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [9:0]   i_req_len_dw;
  logic [7:0]   i_req_tag;
  logic [15:0]  i_req_requester_id;
  logic [6:0]   i_req_lower_addr;
  logic         o_req_err;
  logic [255:0] i_din_data;
  logic         i_din_valid;
  logic         o_din_ready;
  logic [255:0] o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_tx_sop;
  logic         o_tx_eop;
  logic [1:0]   o_tx_empty;

  always #5 clk = ~clk;

  pcie_cpld_tx_generator #(.MAX_PAYLOAD_DW(MPS)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_cfg_completer_id(i_cfg_completer_id),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_len_dw(i_req_len_dw),
    .i_req_tag(i_req_tag), .i_req_requester_id(i_req_requester_id),
    .i_req_lower_addr(i_req_lower_addr), .o_req_err(o_req_err), .i_din_data(i_din_data),
    .i_din_valid(i_din_valid), .o_din_ready(o_din_ready), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_sop(o_tx_sop),
    .o_tx_eop(o_tx_eop), .o_tx_empty(o_tx_empty)
  );

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [1:0]   empty;
  } beat_t;

  typedef struct {
    logic [9:0]  len;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [15:0] rid;
    logic [15:0] cid;
    int          beats;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [1:0]  last_empty;
  } vec_t;

  beat_t        exp_q[$];
  beat_t        got_log[$];
  logic [255:0] din_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rdy_pct = 100;
  int           din_pct = 100;
  logic         force_din = 1'b0;
  logic         idle_watch = 1'b0;
  logic         prev_stall = 1'b0;
  beat_t        held;
  logic         err_pending = 1'b0;
  logic         req_bad = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Expected completion stream from the rules: header DWs followed by payload, chopped into
  // 8-DW beats, zero padded at the end of each completion.
  task automatic model_push(input int total, input logic [7:0] tag, input logic [6:0] addr,
                            input logic [15:0] rid, input logic [15:0] cid,
                            input logic [31:0] pl[$]);
    int          rem, off, n, nb;
    logic [6:0]  a;
    logic [31:0] dws[$];
    beat_t       b;
    rem = total;
    off = 0;
    a   = addr;
    while (rem > 0) begin
      n = (rem < MPS) ? rem : MPS;
      dws = {};
      dws.push_back(32'h4A00_0000 | 32'(n % 1024));
      dws.push_back({cid, 4'h0, 12'((rem * 4) % 4096)});
      dws.push_back({rid, tag, 1'b0, a});
      dws.push_back(32'h0);
      for (int k = 0; k < n; k++) dws.push_back(pl[off + k]);
      while (dws.size() % 8 != 0) dws.push_back(32'h0);
      nb = dws.size() / 8;
      for (int j = 0; j < nb; j++) begin
        for (int i = 0; i < 8; i++) b.data[32*i +: 32] = dws[j*8 + i];
        b.sop   = (j == 0);
        b.eop   = (j == nb - 1);
        b.empty = b.eop ? 2'((8 * nb - (4 + n)) / 2) : 2'd0;
        exp_q.push_back(b);
      end
      rem -= n;
      off += n;
      a = 7'((int'(a) + 4 * n) % 128);
    end
  endtask

  task automatic cycle();
    beat_t cur, e;
    logic  acc;
    acc = 1'b0;
    @(negedge clk);
    cur.data  = o_tx_data;
    cur.sop   = o_tx_sop;
    cur.eop   = o_tx_eop;
    cur.empty = o_tx_empty;
    if (prev_stall) begin
      chk("hold_data", cur.data, held.data);
      chk("hold_ctl", {o_tx_valid, cur.sop, cur.eop, cur.empty}, {1'b1, held.sop, held.eop,
          held.empty});
    end
    prev_stall = o_tx_valid && !i_tx_ready;
    held = cur;
    if (o_tx_valid && i_tx_ready) begin
      got_log.push_back(cur);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_beat: got %h sop %b eop %b, required no beat",
                 cur.data, cur.sop, cur.eop);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", cur.data, e.data);
        chk("tx_sop_eop_empty", {cur.sop, cur.eop, cur.empty}, {e.sop, e.eop, e.empty});
      end
    end
    if (i_din_valid && o_din_ready) begin
      if (din_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL din_consumed: got din_ready 1 with no payload pending, required 0");
      end else begin
        void'(din_q.pop_front());
      end
    end
    chk("req_err", 256'(o_req_err), 256'(err_pending));
    err_pending = 1'b0;
    if (i_req_valid && o_req_ready) begin
      acc = 1'b1;
      err_pending = req_bad;
    end
    if (idle_watch) begin
      chk("idle_din_ready", 256'(o_din_ready), 256'(0));
      chk("idle_tx_valid", 256'(o_tx_valid), 256'(0));
    end
    @(posedge clk);
    #1;
    if (acc) i_req_valid = 1'b0;
    i_tx_ready = ($urandom_range(0, 99) < rdy_pct);
    if (din_q.size() > 0) begin
      i_din_valid = ($urandom_range(0, 99) < din_pct);
      i_din_data  = din_q[0];
    end else begin
      i_din_valid = force_din;
      for (int i = 0; i < 8; i++) i_din_data[32*i +: 32] = $urandom();
    end
  endtask

  // pat != 0 gives payload DW k = {pat, k}; pat == 0 gives random payload
  task automatic send_req(input logic [9:0] len, input logic [7:0] tag, input logic [6:0] addr,
                          input logic [15:0] rid, input logic [15:0] cid, input logic [15:0] pat);
    int           total, nb, t;
    logic [31:0]  pl[$];
    logic [255:0] bt;
    logic         bad;
    total = (len == 10'd0) ? 1024 : int'(len);
    bad   = (addr[2:0] != 3'd0);
    if (!bad) begin
      nb = (total + 7) / 8;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 8; i++) begin
          if (b * 8 + i < total) begin
            bt[32*i +: 32] = (pat != 16'd0) ? {pat, 16'(b * 8 + i)} : $urandom();
            pl.push_back(bt[32*i +: 32]);
          end else begin
            bt[32*i +: 32] = $urandom() | 32'h1;
          end
        end
        din_q.push_back(bt);
      end
      model_push(total, tag, addr, rid, cid, pl);
    end
    i_req_len_dw       = len;
    i_req_tag          = tag;
    i_req_lower_addr   = addr;
    i_req_requester_id = rid;
    i_cfg_completer_id = cid;
    req_bad            = bad;
    i_req_valid        = 1'b1;
    t = 0;
    while (i_req_valid && t < 300) begin
      cycle();
      t++;
    end
    if (i_req_valid) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got no accept in %0d cycles, required accept", t);
      i_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || din_q.size() != 0 || err_pending) && t < 5000) begin
      cycle();
      t++;
    end
    chk("drain_beats_left", 256'(exp_q.size()), 256'(0));
    for (int i = 0; i < 3; i++) cycle();
  endtask

  vec_t vecs[7];
  int   vbase[7];

  initial begin
    int base, last;
    logic [9:0] rl;
    logic [6:0] ra;

    vecs[0] = '{10'd1,  8'h00, 7'h00, 16'h0000, 16'h00F9, 1,   32'h4A000001, 32'h00F90004,
                32'h00000000, 2'd1};
    vecs[1] = '{10'd8,  8'h11, 7'h08, 16'h1234, 16'h0100, 2,   32'h4A000008, 32'h01000020,
                32'h12341108, 2'd2};
    vecs[2] = '{10'd18, 8'h5A, 7'h00, 16'hBEEF, 16'h0042, 4,   32'h4A000010, 32'h00420048,
                32'hBEEF5A00, 2'd1};
    vecs[3] = '{10'd5,  8'h01, 7'h10, 16'hCAFE, 16'h1111, 2,   32'h4A000005, 32'h11110014,
                32'hCAFE0110, 2'd3};
    vecs[4] = '{10'd12, 8'h02, 7'h20, 16'h0000, 16'h0000, 2,   32'h4A00000C, 32'h00000030,
                32'h00000220, 2'd0};
    vecs[5] = '{10'd4,  8'h03, 7'h78, 16'h0003, 16'h0007, 1,   32'h4A000004, 32'h00070010,
                32'h00030378, 2'd0};
    vecs[6] = '{10'd0,  8'hFF, 7'h78, 16'h0001, 16'hABCD, 192, 32'h4A000010, 32'hABCD0000,
                32'h0001FF78, 2'd2};

    i_reset_n = 1'b0;
    i_req_valid = 1'b0;
    i_req_len_dw = '0;
    i_req_tag = '0;
    i_req_lower_addr = '0;
    i_req_requester_id = '0;
    i_cfg_completer_id = '0;
    i_din_data = '0;
    i_din_valid = 1'b0;
    i_tx_ready = 1'b1;

    #2;
    chk("rst_outputs", {o_req_ready, o_req_err, o_din_ready, o_tx_valid, o_tx_sop, o_tx_eop,
        o_tx_empty}, '0);
    chk("rst_tx_data", o_tx_data, '0);
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("req_ready_idle", 256'(o_req_ready), 256'(1));

    // Directed table, always-ready sink
    for (int v = 0; v < 7; v++) begin
      vbase[v] = got_log.size();
      send_req(vecs[v].len, vecs[v].tag, vecs[v].addr, vecs[v].rid, vecs[v].cid, 16'(v + 1));
      drain();
      base = vbase[v];
      chk("vec_beats", 256'(got_log.size() - base), 256'(vecs[v].beats));
      if (got_log.size() > base) begin
        last = got_log.size() - 1;
        chk("vec_dw0", got_log[base].data[31:0], vecs[v].dw0);
        chk("vec_dw1", got_log[base].data[63:32], vecs[v].dw1);
        chk("vec_dw2", got_log[base].data[95:64], vecs[v].dw2);
        chk("vec_last_empty", {got_log[last].eop, got_log[last].empty},
            {1'b1, vecs[v].last_empty});
      end
    end
    if (got_log.size() > vbase[0]) begin
      chk("t1_payload_dw4", got_log[vbase[0]].data[159:128], 32'h00010000);
      chk("t1_unused_zero", got_log[vbase[0]].data[255:160], '0);
    end
    if (got_log.size() > vbase[2] + 3) begin
      chk("t3_b_hdr", got_log[vbase[2] + 3].data[95:0], {32'hBEEF5A40, 32'h00420008,
          32'h4A000002});
      chk("t3_b_payload", got_log[vbase[2] + 3].data[191:128], {32'h00030011, 32'h00030010});
    end

    // Misaligned request: error pulse, nothing consumed even with din offered
    idle_watch = 1'b1;
    force_din  = 1'b1;
    send_req(10'd4, 8'h77, 7'h04, 16'h5555, 16'h6666, 16'h0);
    for (int i = 0; i < 4; i++) cycle();
    chk("err_no_tx", 256'(exp_q.size()), 256'(0));
    idle_watch = 1'b0;
    force_din  = 1'b0;
    cycle();
    send_req(10'd3, 8'h78, 7'h40, 16'h5555, 16'h6666, 16'h0);
    drain();

    // Backpressure and input gaps
    rdy_pct = 50;
    din_pct = 60;
    send_req(10'd32, 8'h20, 7'h00, 16'hA5A5, 16'h5A5A, 16'h0);
    drain();
    for (int r = 0; r < 25; r++) begin
      rl = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(49, 130)) : 10'($urandom_range(1, 48));
      ra = {4'($urandom()), 3'b000};
      if ($urandom_range(0, 9) == 0) ra[2:0] = 3'($urandom_range(1, 7));
      send_req(rl, 8'($urandom()), ra, 16'($urandom()), 16'($urandom()), 16'h0);
      drain();
    end

    // Reset while the second beat of a 3-beat completion is on the bus
    rdy_pct = 100;
    din_pct = 100;
    base = got_log.size();
    send_req(10'd16, 8'h44, 7'h00, 16'h1111, 16'h2222, 16'h0);
    for (int t = 0; t < 50 && got_log.size() == base; t++) cycle();
    chk("rst_pre_valid", 256'(o_tx_valid), 256'(1));
    i_reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {o_req_ready, o_req_err, o_din_ready, o_tx_valid, o_tx_sop, o_tx_eop,
        o_tx_empty}, '0);
    chk("midrst_tx_data", o_tx_data, '0);
    exp_q = {};
    din_q = {};
    prev_stall  = 1'b0;
    err_pending = 1'b0;
    i_din_valid = 1'b0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    base = got_log.size();
    send_req(10'd1, 8'h00, 7'h00, 16'h0000, 16'h00F9, 16'h0001);
    drain();
    chk("post_rst_beats", 256'(got_log.size() - base), 256'(1));
    if (got_log.size() > base)
      chk("post_rst_beat", got_log[base].data[159:0], {32'h00010000, 32'h0, 32'h0, 32'h00F90004,
          32'h4A000001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion of test sequence, required finish");
    $fatal(1, "timeout");
  end

endmodule
